// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: ALU select codes, divider FSM state encoding, XLEN.
package rv32im_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_DIV  = 5'b11000;
    localparam logic [4:0] ALU_DIVU = 5'b11001;
    localparam logic [4:0] ALU_REM  = 5'b11010;
    localparam logic [4:0] ALU_REMU = 5'b11011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    // DIV/DIVU/REM/REMU share the prefix 3'b110; bit0 = unsigned, bit1 = remainder.
    function automatic logic is_div_op(input logic [4:0] sel);
        return sel[4:2] == 3'b110;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-divide step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
    import rv32im_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    // One extra bit keeps the shifted remainder exact when the divisor is above 2^31.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_msb};
        diff    = shifted - {1'b0, dvs};
        q_bit   = ~diff[XLEN];
        rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/alu_div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer that stalls EX while a 32-step restoring divide runs.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow straight from INIT.
module alu_div_sequencer
    import rv32im_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      select,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic [XLEN-1:0] result,
    output logic            valid,
    output logic            busy,
    output logic            stall,
    output div_state_e      state_dbg
);

    div_state_e       state_q;
    logic [XLEN-1:0]  dvd;
    logic [XLEN-1:0]  dvs;
    logic [XLEN-1:0]  rem;
    logic [CNT_W-1:0] cnt;
    logic             op_signed;
    logic             op_rem;
    logic             neg_q;
    logic             neg_r;

    logic            accept;
    logic            sign1;
    logic            sign2;
    logic            div_zero;
    logic [XLEN-1:0] step_rem;
    logic            step_q;

    assign accept    = start & is_div_op(select) & ((state_q == IDLE) | (state_q == DONE));
    assign stall     = accept | busy;
    assign state_dbg = state_q;

    assign sign1    = op_signed & dvd[XLEN-1];
    assign sign2    = op_signed & dvs[XLEN-1];
    assign div_zero = (dvs == '0);

`ifdef DIV_EARLY_OUT_EN
    logic sgn_ovf;
    assign sgn_ovf = op_signed & (dvd == {1'b1, {(XLEN-1){1'b0}}}) & (dvs == '1);
`endif

    div_step u_div_step (
        .rem_in  (rem),
        .dvd_msb (dvd[XLEN-1]),
        .dvs     (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // dvd doubles as the quotient accumulator: quotient bits shift in as dividend bits shift out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            op_signed <= 1'b0;
            op_rem    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result    <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        dvd       <= data1;
                        dvs       <= data2;
                        op_signed <= ~select[0];
                        op_rem    <= select[1];
                        busy      <= 1'b1;
                        state_q   <= INIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                INIT: begin
                    dvd     <= sign1 ? -dvd : dvd;
                    dvs     <= sign2 ? -dvs : dvs;
                    // A zero divisor must yield all-ones whatever the dividend sign.
                    neg_q   <= (sign1 ^ sign2) & ~div_zero;
                    neg_r   <= sign1;
                    rem     <= '0;
                    cnt     <= '0;
                    state_q <= ITER;
`ifdef DIV_EARLY_OUT_EN
                    if (div_zero) begin
                        result  <= op_rem ? dvd : '1;
                        busy    <= 1'b0;
                        valid   <= 1'b1;
                        state_q <= DONE;
                    end else if (sgn_ovf) begin
                        result  <= op_rem ? '0 : dvd;
                        busy    <= 1'b0;
                        valid   <= 1'b1;
                        state_q <= DONE;
                    end
`endif
                end
                ITER: begin
                    rem <= step_rem;
                    dvd <= {dvd[XLEN-2:0], step_q};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (op_rem) begin
                        result <= neg_r ? -rem : rem;
                    end else begin
                        result <= neg_q ? -dvd : dvd;
                    end
                    busy    <= 1'b0;
                    valid   <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer: hand-computed RV32M results, latency, stall, busy and reset behaviour.
module tb_alu_div_sequencer;
    import rv32im_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  select;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] result;
    logic        valid;
    logic        busy;
    logic        stall;
    div_state_e  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    localparam int FULL_LAT = 35;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 35;
`endif

    alu_div_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .select    (select),
        .data1     (data1),
        .data2     (data2),
        .result    (result),
        .valid     (valid),
        .busy      (busy),
        .stall     (stall),
        .state_dbg (state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic drive_start(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        select = sel;
        data1  = a;
        data2  = b;
    endtask

    // Called at the negedge of the cycle in which start is driven (cycle 0); returns on the VALID cycle.
    task automatic wait_done(input logic [31:0] exp_res, input int exp_lat, input int inject_at,
                             input string tag);
        int          cyc;
        logic        stall_gap;
        logic [31:0] e;
        exp_q.push_back(exp_res);
        #1;
        stall_gap = !stall;
        @(negedge clk);
        cyc   = 1;
        start = 1'b0;
        while (!valid && cyc < 100) begin
            if (!stall) stall_gap = 1'b1;
            if (cyc == inject_at) drive_start(ALU_DIVU, 32'd1000, 32'd1);
            else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " stall gap"}, {31'b0, stall_gap}, 32'd0);
        check({tag, " busy at valid"}, {31'b0, busy}, 32'd0);
        e = exp_q.pop_front();
        check({tag, " result"}, result, e);
    endtask

    task automatic do_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit special, input string tag);
        @(negedge clk);
        drive_start(sel, a, b);
        wait_done(exp_res, special ? EARLY_LAT : FULL_LAT, 0, tag);
    endtask

    initial begin
        int seen_valid;
        reset  = 1'b1;
        start  = 1'b0;
        select = 5'b0;
        data1  = 32'b0;
        data2  = 32'b0;
        repeat (3) @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset valid", {31'b0, valid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset state", {29'b0, state_dbg}, {29'b0, IDLE});
        reset = 1'b0;

        // non-divide select code is ignored
        @(negedge clk);
        drive_start(5'b00000, 32'd5, 32'd3);
        #1;
        check("nondiv stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("nondiv busy", {31'b0, busy}, 32'd0);
        check("nondiv state", {29'b0, state_dbg}, {29'b0, IDLE});

        do_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu 100/7");
        @(negedge clk);
        check("valid pulse width", {31'b0, valid}, 32'd0);
        check("done to idle", {29'b0, state_dbg}, {29'b0, IDLE});
        do_op(ALU_REMU, 32'd100, 32'd7, 32'd2, 1'b0, "remu 100/7");
        do_op(ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, "rem -7/2");
        do_op(ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, "div -7/2");
        do_op(ALU_DIV, 32'd20, 32'hFFFFFFFA, 32'hFFFFFFFD, 1'b0, "div 20/-6");
        do_op(ALU_REM, 32'd20, 32'hFFFFFFFA, 32'd2, 1'b0, "rem 20/-6");
        do_op(ALU_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0, "divu big");
        do_op(ALU_REMU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0, "remu big");
        do_op(ALU_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, "divu 5/0");
        do_op(ALU_REMU, 32'd5, 32'd0, 32'd5, 1'b1, "remu 5/0");
        do_op(ALU_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1'b1, "div -5/0");
        do_op(ALU_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1'b1, "rem -5/0");
        do_op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div ovf");
        do_op(ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, "rem ovf");
        do_op(ALU_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, "divu no ovf");

        // start while busy must not disturb the latched operands
        @(negedge clk);
        drive_start(ALU_DIVU, 32'd100, 32'd7);
        wait_done(32'd14, FULL_LAT, 10, "busy ignore");

        // back-to-back: second op accepted on the VALID cycle
        do_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "b2b first");
        drive_start(ALU_REMU, 32'd100, 32'd7);
        wait_done(32'd2, FULL_LAT, 0, "b2b second");

        // reset in cycle 20 of a DIV
        @(negedge clk);
        drive_start(ALU_DIV, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset state", {29'b0, state_dbg}, {29'b0, IDLE});
        check("midreset result", result, 32'd0);
        check("midreset valid", {31'b0, valid}, 32'd0);
        check("midreset busy", {31'b0, busy}, 32'd0);
        seen_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) seen_valid++;
        end
        check("midreset no valid", 32'(seen_valid), 32'd0);
        do_op(ALU_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, "divu 9/3 after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
